stopwatch_time_counter: RTL and testbench
=========================================

Name: stopwatch_time_counter

Overview:
- Consumer end of the 50 MHz→100 Hz clock divider: receives the divider's CLK_100Hz output as a data signal, synchronises and edge-detects it in the CLK_50MHz domain, and uses each detected edge as a 10 ms tick.
- Holds the stopwatch time as BCD MM:SS.cc, supports start/stop, lap-freeze and clear, and drives the digit values to the display logic.

Parameters:
- SYNC_STAGES, 2: flops in the CLK_100Hz synchroniser chain (minimum 2).
- MIN_TENS_MAX, 5: maximum minutes-tens digit. The wrap point is (MIN_TENS_MAX)9:59.99.

Ports:
- CLK_50MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- CLK_100Hz  in  1  divider output, asynchronous to this logic; treated as data.
- btn_start_stop  in  1  single-cycle pulse, already debounced.
- btn_lap_reset  in  1  single-cycle pulse, already debounced.
- cs_ones, cs_tens  out  4 each  centisecond digits shown.
- sec_ones, sec_tens  out  4 each  second digits shown.
- min_ones, min_tens  out  4 each  minute digits shown.
- running  out  1  high in RUNNING or LAP.
- lap_held  out  1  high in LAP (display frozen).
- wrap_pulse  out  1  one-cycle pulse when time rolls over to zero.

Behaviour:
- Reset (reset_n low, async): state=IDLE; synchroniser, edge flop, counters and snapshot all 0; every output 0.
- Tick path: CLK_100Hz → SYNC_STAGES flops → one edge flop; tick = synced & ~prev.
  - The counter register changes SYNC_STAGES+1 CLK_50MHz edges after a CLK_100Hz rising edge.
  - A spurious tick just after reset release is harmless because the state is IDLE.
- Counting:
  - Enable = tick AND current state ∈ {RUNNING, LAP}. Current state means the registered value, before any transition in that cycle.
  - Cascade: cs_ones 0-9 → cs_tens 0-9 → sec_ones 0-9 → sec_tens 0-5 → min_ones 0-9 → min_tens 0-MIN_TENS_MAX. Each digit carries when it and all lower digits are at their max.
  - Wrap: at max time, the next tick sets all digits to 0 and asserts wrap_pulse for exactly that cycle. Counting continues.
- FSM (btn_start_stop has priority; if both pulses arrive in the same cycle, btn_lap_reset is discarded):
  - IDLE:
    - start_stop → RUNNING.
    - lap_reset ignored.
  - RUNNING:
    - start_stop → PAUSED.
    - lap_reset → LAP; the snapshot captures the current (pre-increment) counter value.
  - LAP:
    - Counting continues.
    - lap_reset → RUNNING (display returns to live).
    - start_stop → PAUSED (display returns to live, showing the stopped time).
  - PAUSED:
    - start_stop → RUNNING.
    - lap_reset → IDLE; counters and snapshot are cleared in that same cycle.
- Display mux: digit outputs equal the snapshot registers in LAP and the counter registers otherwise. There is no added latency; the outputs are register-driven through the mux only.
- running and lap_held are decoded directly from the state register.
- Tick in the same cycle as a RUNNING→PAUSED transition: the tick is counted.
- Tick in the same cycle as a PAUSED→RUNNING transition: the tick is not counted.
- Reset asserted mid-count or in LAP: immediate return to the reset values above.

Decomposition:
- stopwatch_pkg holds:
  - state encoding: IDLE, RUNNING, LAP, PAUSED (2 bits);
  - BCD digit-max constants: 9, 5;
  - the digit width constant (4).
- Sub-module bcd_digit_counter:
  - parameter MAX;
  - inputs: clk, reset_n, clr, inc;
  - outputs: digit[3:0], carry (inc & digit==MAX).
  - Instantiated six times and chained via carry.
- FSM, synchroniser, snapshot and display mux live in the top module.

Test Plan (bench drives CLK_100Hz directly with a 200-cycle period instead of waiting for the real divider):
1. Reset and IDLE: reset_n low for 10 cycles while CLK_100Hz toggles → all outputs 0. After release, 20 ticks → display stays 00:00.00, running=0.
2. Start and count: start_stop pulse, then 123 CLK_100Hz rising edges → display 00:01.23, running=1. The cs_ones change is measured at exactly 3 clocks after the CLK_100Hz rise.
3. Lap freeze: run 50 ticks, lap_reset → lap_held=1, display held at 00:00.50 through 30 more ticks. A second lap_reset → lap_held=0, display 00:00.80.
4. Pause and clear: start, 10 ticks, start_stop → 10 further ticks leave the display at 00:00.10. Then lap_reset → IDLE, display 00:00.00, running=0.
5. Wrap: 359999 ticks → 59:59.99. The next tick → 00:00.00 with wrap_pulse high for one cycle, and running stays 1.
6. Simultaneous events in RUNNING at 00:00.07:
   - start_stop and lap_reset in the same cycle as a tick → state PAUSED, lap_held=0, display 00:00.08.
   - start_stop coincident with a tick in PAUSED → RUNNING, display still 00:00.08.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, digit constants and time type for the stopwatch
package stopwatch_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX9 = 9;
  localparam int BCD_MAX5 = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    LAP     = 2'd2,
    PAUSED  = 2'd3
  } sw_state_e;

  // Full MM:SS.cc value, most significant digit first so it reads like the display
  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
    logic [DIGIT_W-1:0] cs_tens;
    logic [DIGIT_W-1:0] cs_ones;
  } bcd_time_t;

endpackage

// File: rtl/stopwatch_time_counter_if.sv
// rtl/stopwatch_time_counter_if.sv - tick/button inputs and display outputs of the stopwatch
interface stopwatch_time_counter_if;
  import stopwatch_pkg::*;

  logic               CLK_100Hz;
  logic               btn_start_stop;
  logic               btn_lap_reset;
  logic [DIGIT_W-1:0] cs_ones;
  logic [DIGIT_W-1:0] cs_tens;
  logic [DIGIT_W-1:0] sec_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] min_tens;
  logic               running;
  logic               lap_held;
  logic               wrap_pulse;

  modport master (
    output CLK_100Hz, btn_start_stop, btn_lap_reset,
    input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    input  running, lap_held, wrap_pulse
  );

  modport slave (
    input  CLK_100Hz, btn_start_stop, btn_lap_reset,
    output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    output running, lap_held, wrap_pulse
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD digit counting 0..MAX with a carry out for chaining
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;
  logic               at_max;

  assign at_max = (digit_q == MAX_D);
  assign carry  = inc & at_max;
  assign digit  = digit_q;

  // Next digit: clear wins, otherwise advance and roll to zero past MAX
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = at_max ? '0 : digit_q + 1'b1;
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// rtl/stopwatch_time_counter.sv - BCD MM:SS.cc stopwatch driven by a synchronised 100 Hz tick
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic                     CLK_50MHz,
  input  logic                     reset_n,
  stopwatch_time_counter_if.slave  sw
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   synced;
  logic                   tick;

  sw_state_e              state_q;
  sw_state_e              state_d;
  bcd_time_t              snap_q;
  bcd_time_t              snap_d;
  logic                   wrap_q;
  logic                   wrap_d;

  bcd_time_t              cnt;
  bcd_time_t              disp;
  logic                   count_en;
  logic                   clear;
  logic                   lap_capture;
  logic                   start_stop;
  logic                   lap_reset;

  logic                   c_cs_ones;
  logic                   c_cs_tens;
  logic                   c_sec_ones;
  logic                   c_sec_tens;
  logic                   c_min_ones;
  logic                   c_min_tens;

  // CLK_100Hz is asynchronous data: shift it through the chain, then rising-edge detect
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sw.CLK_100Hz};
    prev_d = synced;
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign tick   = synced & ~prev_q;

  // Synchroniser and edge-detect registers
  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Start/stop has priority, so a coincident lap/reset pulse is dropped
  assign start_stop = sw.btn_start_stop;
  assign lap_reset  = sw.btn_lap_reset & ~sw.btn_start_stop;

  // Counting is gated by the state held before this cycle's transition
  assign count_en = tick & ((state_q == RUNNING) || (state_q == LAP));

  // Next state plus the one-cycle lap capture and clear strobes
  always_comb begin
    state_d     = state_q;
    lap_capture = 1'b0;
    clear       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop) state_d = RUNNING;
      end
      RUNNING: begin
        if (start_stop) begin
          state_d = PAUSED;
        end else if (lap_reset) begin
          state_d     = LAP;
          lap_capture = 1'b1;
        end
      end
      LAP: begin
        if (start_stop) begin
          state_d = PAUSED;
        end else if (lap_reset) begin
          state_d = RUNNING;
        end
      end
      PAUSED: begin
        if (start_stop) begin
          state_d = RUNNING;
        end else if (lap_reset) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot takes the pre-increment count on lap entry and is wiped with the counters
  always_comb begin
    snap_d = snap_q;
    if (clear) begin
      snap_d = '0;
    end else if (lap_capture) begin
      snap_d = cnt;
    end
  end

  // Rollover of the top digit marks the cycle the time returns to zero
  always_comb begin
    wrap_d = c_min_tens;
  end

  // State, snapshot and wrap flag registers
  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      wrap_q  <= wrap_d;
    end
  end

  bcd_digit_counter #(.MAX(BCD_MAX9)) u_cs_ones (
    .clk     (CLK_50MHz),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (count_en),
    .digit   (cnt.cs_ones),
    .carry   (c_cs_ones)
  );

  bcd_digit_counter #(.MAX(BCD_MAX9)) u_cs_tens (
    .clk     (CLK_50MHz),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (c_cs_ones),
    .digit   (cnt.cs_tens),
    .carry   (c_cs_tens)
  );

  bcd_digit_counter #(.MAX(BCD_MAX9)) u_sec_ones (
    .clk     (CLK_50MHz),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (c_cs_tens),
    .digit   (cnt.sec_ones),
    .carry   (c_sec_ones)
  );

  bcd_digit_counter #(.MAX(BCD_MAX5)) u_sec_tens (
    .clk     (CLK_50MHz),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (c_sec_ones),
    .digit   (cnt.sec_tens),
    .carry   (c_sec_tens)
  );

  bcd_digit_counter #(.MAX(BCD_MAX9)) u_min_ones (
    .clk     (CLK_50MHz),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (c_sec_tens),
    .digit   (cnt.min_ones),
    .carry   (c_min_ones)
  );

  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk     (CLK_50MHz),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (c_min_ones),
    .digit   (cnt.min_tens),
    .carry   (c_min_tens)
  );

  // Frozen lap time is shown only while in LAP; otherwise the live count
  assign disp = (state_q == LAP) ? snap_q : cnt;

  assign sw.cs_ones    = disp.cs_ones;
  assign sw.cs_tens    = disp.cs_tens;
  assign sw.sec_ones   = disp.sec_ones;
  assign sw.sec_tens   = disp.sec_tens;
  assign sw.min_ones   = disp.min_ones;
  assign sw.min_tens   = disp.min_tens;
  assign sw.running    = (state_q == RUNNING) || (state_q == LAP);
  assign sw.lap_held   = (state_q == LAP);
  assign sw.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// tb/tb_stopwatch_time_counter.sv - directed self-checking bench for stopwatch_time_counter
module tb_stopwatch_time_counter;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  stopwatch_time_counter_if sw_if ();

  stopwatch_time_counter #(
    .SYNC_STAGES  (2),
    .MIN_TENS_MAX (5)
  ) dut (
    .CLK_50MHz (clk),
    .reset_n   (reset_n),
    .sw        (sw_if)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [31:0] disp_val();
    return {8'h00, sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens,
            sw_if.sec_ones, sw_if.cs_tens, sw_if.cs_ones};
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One 200-cycle CLK_100Hz period; buttons land in the cycle the tick is seen
  task automatic do_tick(input logic ss, input logic lr);
    @(negedge clk);
    sw_if.CLK_100Hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sw_if.btn_start_stop = ss;
    sw_if.btn_lap_reset  = lr;
    @(negedge clk);
    sw_if.btn_start_stop = 1'b0;
    sw_if.btn_lap_reset  = 1'b0;
    repeat (97) @(negedge clk);
    sw_if.CLK_100Hz = 1'b0;
    repeat (100) @(negedge clk);
  endtask

  task automatic pulse_btn(input logic ss, input logic lr);
    @(negedge clk);
    sw_if.btn_start_stop = ss;
    sw_if.btn_lap_reset  = lr;
    @(negedge clk);
    sw_if.btn_start_stop = 1'b0;
    sw_if.btn_lap_reset  = 1'b0;
    @(negedge clk);
  endtask

  // RUNNING -> PAUSED -> IDLE (clear) -> RUNNING
  task automatic restart_from_zero();
    pulse_btn(1'b1, 1'b0);
    pulse_btn(1'b0, 1'b1);
    pulse_btn(1'b1, 1'b0);
  endtask

  initial begin
    checks               = 0;
    failures             = 0;
    reset_n              = 1'b0;
    sw_if.CLK_100Hz      = 1'b0;
    sw_if.btn_start_stop = 1'b0;
    sw_if.btn_lap_reset  = 1'b0;

    // 1. reset with CLK_100Hz toggling, then ticks in IDLE
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sw_if.CLK_100Hz = ~sw_if.CLK_100Hz;
    end
    chk_eq("rst_disp", disp_val(), 32'h000000);
    chk_eq("rst_running", {31'd0, sw_if.running}, 32'd0);
    chk_eq("rst_lap_held", {31'd0, sw_if.lap_held}, 32'd0);
    chk_eq("rst_wrap", {31'd0, sw_if.wrap_pulse}, 32'd0);
    @(negedge clk);
    sw_if.CLK_100Hz = 1'b0;
    reset_n = 1'b1;
    repeat (20) do_tick(1'b0, 1'b0);
    chk_eq("idle_disp", disp_val(), 32'h000000);
    chk_eq("idle_running", {31'd0, sw_if.running}, 32'd0);

    // 2. start and count 123 ticks, measuring latency on the last one
    pulse_btn(1'b1, 1'b0);
    chk_eq("start_running", {31'd0, sw_if.running}, 32'd1);
    repeat (122) do_tick(1'b0, 1'b0);
    chk_eq("count_122", disp_val(), 32'h000122);
    @(negedge clk);
    sw_if.CLK_100Hz = 1'b1;
    @(negedge clk);
    chk_eq("lat_edge1", {28'd0, sw_if.cs_ones}, 32'd2);
    @(negedge clk);
    chk_eq("lat_edge2", {28'd0, sw_if.cs_ones}, 32'd2);
    @(negedge clk);
    chk_eq("lat_edge3", {28'd0, sw_if.cs_ones}, 32'd3);
    repeat (97) @(negedge clk);
    sw_if.CLK_100Hz = 1'b0;
    repeat (100) @(negedge clk);
    chk_eq("count_123", disp_val(), 32'h000123);
    chk_eq("count_running", {31'd0, sw_if.running}, 32'd1);

    // 3. lap freeze
    restart_from_zero();
    chk_eq("restart_disp", disp_val(), 32'h000000);
    repeat (50) do_tick(1'b0, 1'b0);
    pulse_btn(1'b0, 1'b1);
    chk_eq("lap_held_on", {31'd0, sw_if.lap_held}, 32'd1);
    chk_eq("lap_disp_50", disp_val(), 32'h000050);
    repeat (30) do_tick(1'b0, 1'b0);
    chk_eq("lap_frozen", disp_val(), 32'h000050);
    chk_eq("lap_running", {31'd0, sw_if.running}, 32'd1);
    pulse_btn(1'b0, 1'b1);
    chk_eq("lap_held_off", {31'd0, sw_if.lap_held}, 32'd0);
    chk_eq("lap_live_80", disp_val(), 32'h000080);

    // 4. pause then clear
    restart_from_zero();
    repeat (10) do_tick(1'b0, 1'b0);
    pulse_btn(1'b1, 1'b0);
    chk_eq("pause_running", {31'd0, sw_if.running}, 32'd0);
    repeat (10) do_tick(1'b0, 1'b0);
    chk_eq("pause_disp", disp_val(), 32'h000010);
    pulse_btn(1'b0, 1'b1);
    chk_eq("clear_disp", disp_val(), 32'h000000);
    chk_eq("clear_running", {31'd0, sw_if.running}, 32'd0);
    chk_eq("clear_lap_held", {31'd0, sw_if.lap_held}, 32'd0);

    // 5. wrap: preload 59:59.97 in IDLE instead of 359997 real ticks
    @(negedge clk);
    force dut.u_cs_ones.digit_q  = 4'd7;
    force dut.u_cs_tens.digit_q  = 4'd9;
    force dut.u_sec_ones.digit_q = 4'd9;
    force dut.u_sec_tens.digit_q = 4'd5;
    force dut.u_min_ones.digit_q = 4'd9;
    force dut.u_min_tens.digit_q = 4'd5;
    @(negedge clk);
    release dut.u_cs_ones.digit_q;
    release dut.u_cs_tens.digit_q;
    release dut.u_sec_ones.digit_q;
    release dut.u_sec_tens.digit_q;
    release dut.u_min_ones.digit_q;
    release dut.u_min_tens.digit_q;
    @(negedge clk);
    chk_eq("preload_disp", disp_val(), 32'h595997);
    pulse_btn(1'b1, 1'b0);
    repeat (2) do_tick(1'b0, 1'b0);
    chk_eq("max_disp", disp_val(), 32'h595999);
    chk_eq("max_no_wrap", {31'd0, sw_if.wrap_pulse}, 32'd0);
    @(negedge clk);
    sw_if.CLK_100Hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_eq("prewrap_pulse", {31'd0, sw_if.wrap_pulse}, 32'd0);
    @(negedge clk);
    chk_eq("wrap_disp", disp_val(), 32'h000000);
    chk_eq("wrap_pulse_hi", {31'd0, sw_if.wrap_pulse}, 32'd1);
    chk_eq("wrap_running", {31'd0, sw_if.running}, 32'd1);
    @(negedge clk);
    chk_eq("wrap_pulse_lo", {31'd0, sw_if.wrap_pulse}, 32'd0);
    repeat (96) @(negedge clk);
    sw_if.CLK_100Hz = 1'b0;
    repeat (100) @(negedge clk);
    do_tick(1'b0, 1'b0);
    chk_eq("post_wrap_count", disp_val(), 32'h000001);

    // 6. coincident buttons and ticks
    restart_from_zero();
    repeat (7) do_tick(1'b0, 1'b0);
    chk_eq("sim_pre", disp_val(), 32'h000007);
    do_tick(1'b1, 1'b1);
    chk_eq("sim_pause_disp", disp_val(), 32'h000008);
    chk_eq("sim_pause_running", {31'd0, sw_if.running}, 32'd0);
    chk_eq("sim_pause_lap", {31'd0, sw_if.lap_held}, 32'd0);
    do_tick(1'b1, 1'b0);
    chk_eq("sim_resume_running", {31'd0, sw_if.running}, 32'd1);
    chk_eq("sim_resume_disp", disp_val(), 32'h000008);
    do_tick(1'b0, 1'b0);
    chk_eq("sim_after_disp", disp_val(), 32'h000009);

    // async reset mid-count
    @(negedge clk);
    #3 reset_n = 1'b0;
    #2;
    chk_eq("async_rst_disp", disp_val(), 32'h000000);
    chk_eq("async_rst_running", {31'd0, sw_if.running}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
